// File: rtl/ntt_mult_sequencer_if.sv
// ntt_mult_sequencer_if
//   Bundles the sequencer's control handshake, the shared f/g/zeta read port,
//   the base-case multiplier operand/result lanes and the h write port.
//   master : sequencer side (drives reads, operands, writes, busy/done)
//   slave  : environment side (memories, multiplier, start/stall source)
//   Signals:
//     start, stall          control requests into the sequencer
//     busy, done            run status / one-cycle completion pulse
//     rd_en, rd_addr        shared read strobe and pair index for f, g, zetas
//     f_rdata, g_rdata      {coef[2j+1], coef[2j]} read data
//     zeta_rdata            zetas[j] read data
//     mul_a0..mul_gamma     operands presented to the base-case multiplier
//     mul_c0, mul_c1        multiplier results
//     wr_en, wr_addr,       h pair write port, data = {c1, c0}
//     wr_data
interface ntt_mult_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int COEF_W = 16
);
  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [2*COEF_W-1:0]   f_rdata;
  logic [2*COEF_W-1:0]   g_rdata;
  logic [COEF_W-1:0]     zeta_rdata;
  logic [COEF_W-1:0]     mul_a0;
  logic [COEF_W-1:0]     mul_a1;
  logic [COEF_W-1:0]     mul_b0;
  logic [COEF_W-1:0]     mul_b1;
  logic [COEF_W-1:0]     mul_gamma;
  logic [COEF_W-1:0]     mul_c0;
  logic [COEF_W-1:0]     mul_c1;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [2*COEF_W-1:0]   wr_data;

  modport master (
    input  start, stall, f_rdata, g_rdata, zeta_rdata, mul_c0, mul_c1,
    output busy, done, rd_en, rd_addr,
           mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, stall, f_rdata, g_rdata, zeta_rdata, mul_c0, mul_c1,
    input  busy, done, rd_en, rd_addr,
           mul_a0, mul_a1, mul_b0, mul_b1, mul_gamma,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ntt_mult_sequencer.sv
// ntt_mult_sequencer
//   Walks pair index j = 0..N_PAIRS-1 through one shared base-case multiplier:
//   reads {f[2j+1],f[2j]}, {g[2j+1],g[2j]} and zetas[j], passes them straight
//   to the multiplier, and writes {c1,c0} back as h pair j.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (aborts a run immediately)
//     bus    ntt_mult_sequencer_if.master (control, read, multiplier, write)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start
//   S_RUN   | issuing one read per non-stalled cycle, j = 0..N_PAIRS-1
//   S_DRAIN | all reads issued, waiting for the last write to land
//   S_DONE  | one-cycle done pulse, back to S_IDLE next cycle
module ntt_mult_sequencer #(
  parameter int N_PAIRS  = 128,
  parameter int ADDR_W   = 7,
  parameter int COEF_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MULT_LAT = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  ntt_mult_sequencer_if.master bus
);
  localparam int L     = RD_LAT + MULT_LAT;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PAIRS - 1);
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N_PAIRS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]            wr_left_q, wr_left_d;
  logic [L-1:0]                vld_pipe_q, vld_pipe_d;
  logic [L-1:0][ADDR_W-1:0]    addr_pipe_q, addr_pipe_d;
  logic [L:0]                  vld_shift;
  logic [L:0][ADDR_W-1:0]      addr_shift;
  logic                        rd_en;
  logic                        busy;
  logic                        done;
  logic                        wr_en;

  assign wr_en = vld_pipe_q[L-1];

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wr_left_d   = wr_left_q;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    // remaining-write down-counter; terminal count ends the drain
    if (wr_en) wr_left_d = wr_left_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          issue_cnt_d = '0;
          wr_left_d   = N_CNT;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (!bus.stall) begin
          rd_en       = 1'b1;
          issue_cnt_d = issue_cnt_q + ADDR_W'(1);
          if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (wr_en && (wr_left_q == CNT_W'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/address delay line: never stalled, so each write lands exactly
  // L cycles after its read strobe. Element 0 is the newest entry.
  assign vld_shift   = {vld_pipe_q, rd_en};
  assign addr_shift  = {addr_pipe_q, bus.rd_addr};
  assign vld_pipe_d  = vld_shift[L-1:0];
  assign addr_pipe_d = addr_shift[L-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      wr_left_q   <= '0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wr_left_q   <= wr_left_d;
      vld_pipe_q  <= vld_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = issue_cnt_q;
  assign bus.mul_a0    = bus.f_rdata[COEF_W-1:0];
  assign bus.mul_a1    = bus.f_rdata[2*COEF_W-1:COEF_W];
  assign bus.mul_b0    = bus.g_rdata[COEF_W-1:0];
  assign bus.mul_b1    = bus.g_rdata[2*COEF_W-1:COEF_W];
  assign bus.mul_gamma = bus.zeta_rdata;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = addr_pipe_q[L-1];
  assign bus.wr_data   = {bus.mul_c1, bus.mul_c0};
endmodule

// File: tb/tb_ntt_mult_sequencer.sv
`timescale 1ns/1ps
module tb_ntt_mult_sequencer;
  localparam int N   = 128;
  localparam int AW  = 7;
  localparam int CW  = 16;
  localparam int Q   = 3329;
  localparam int LAT = 3;   // read latency 1 + multiplier latency 2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_mult_sequencer_if #(.ADDR_W(AW), .COEF_W(CW)) bus0 ();
  ntt_mult_sequencer_if #(.ADDR_W(AW), .COEF_W(CW)) bus1 ();

  ntt_mult_sequencer #(.N_PAIRS(N), .ADDR_W(AW), .COEF_W(CW), .RD_LAT(1), .MULT_LAT(2))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ntt_mult_sequencer #(.N_PAIRS(N), .ADDR_W(AW), .COEF_W(CW), .RD_LAT(1), .MULT_LAT(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [15:0] f0 [N];
  logic [15:0] f1 [N];
  logic [15:0] g0 [N];
  logic [15:0] g1 [N];
  logic [15:0] zt [N];
  logic [31:0] h0 [N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // base-case product in Z_q[X]/(X^2 - gamma), returned as {c1, c0}
  function automatic logic [31:0] basemul(input logic [15:0] a0, a1, b0, b1, z);
    int c0, c1;
    c0 = (int'(a0) * int'(b0) + ((int'(a1) * int'(b1)) % Q) * int'(z)) % Q;
    c1 = (int'(a0) * int'(b1) + int'(a1) * int'(b0)) % Q;
    return {16'(c1), 16'(c0)};
  endfunction

  function automatic logic [31:0] gold(input int j);
    return basemul(f0[j], f1[j], g0[j], g1[j], zt[j]);
  endfunction

  // ---------------- environment: memories and multipliers ----------------
  always @(posedge clk) begin
    if (bus0.rd_en) begin
      bus0.f_rdata    <= {f1[bus0.rd_addr], f0[bus0.rd_addr]};
      bus0.g_rdata    <= {g1[bus0.rd_addr], g0[bus0.rd_addr]};
      bus0.zeta_rdata <= zt[bus0.rd_addr];
    end
    if (bus1.rd_en) begin
      bus1.f_rdata    <= {f1[bus1.rd_addr], f0[bus1.rd_addr]};
      bus1.g_rdata    <= {g1[bus1.rd_addr], g0[bus1.rd_addr]};
      bus1.zeta_rdata <= zt[bus1.rd_addr];
    end
  end

  logic [31:0] mp1, mp2;
  always @(posedge clk) begin
    mp1 <= basemul(bus0.mul_a0, bus0.mul_a1, bus0.mul_b0, bus0.mul_b1, bus0.mul_gamma);
    mp2 <= mp1;
  end
  assign bus0.mul_c0 = mp2[15:0];
  assign bus0.mul_c1 = mp2[31:16];
  assign {bus1.mul_c1, bus1.mul_c0} =
    basemul(bus1.mul_a0, bus1.mul_a1, bus1.mul_b0, bus1.mul_b1, bus1.mul_gamma);

  always @(posedge clk) if (bus0.wr_en) h0[bus0.wr_addr] <= bus0.wr_data;

  // ---------------- model + per-cycle compare for dut0 ----------------
  int cyc = 0;
  bit m_act = 0;
  bit m_donecyc = 0;
  int m_iss = 0;
  int m_wr = 0;
  int pend_cyc [$];
  int pend_addr [$];
  int start_cyc = 0;
  int obs_done_cyc = -1, obs_done_cnt = 0, obs_wr_cnt = 0, obs_wr0_cyc = -1, obs_rd0_cyc = -1;

  always @(negedge clk) begin
    bit exp_rd, exp_wr;
    if (!rst_n) begin
      chk("reset_outputs",
          {bus0.busy, bus0.done, bus0.rd_en, bus0.wr_en, bus0.rd_addr, bus0.wr_addr}, '0);
      m_act = 0; m_donecyc = 0; m_iss = 0; m_wr = 0;
      pend_cyc.delete(); pend_addr.delete();
    end else begin
      exp_rd = m_act && (m_iss < N) && !bus0.stall;
      exp_wr = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc);
      chk("busy", bus0.busy, m_act);
      chk("done", bus0.done, m_donecyc);
      chk("busy_and_done", bus0.busy & bus0.done, 0);
      chk("rd_en", bus0.rd_en, exp_rd);
      if (exp_rd) chk("rd_addr", bus0.rd_addr, m_iss);
      chk("wr_en", bus0.wr_en, exp_wr);
      if (exp_wr) begin
        chk("wr_addr", bus0.wr_addr, pend_addr[0]);
        chk("wr_data", bus0.wr_data, gold(pend_addr[0]));
      end
      if (bus0.done) begin obs_done_cyc = cyc; obs_done_cnt++; end
      if (bus0.wr_en) begin
        obs_wr_cnt++;
        if (bus0.wr_addr == 0) obs_wr0_cyc = cyc;
      end
      if (bus0.rd_en && bus0.rd_addr == 0) obs_rd0_cyc = cyc;
      // advance model to the next cycle
      if (m_donecyc) m_donecyc = 0;
      else if (!m_act && bus0.start) begin
        m_act = 1; m_iss = 0; m_wr = 0; start_cyc = cyc; obs_wr_cnt = 0;
      end
      if (exp_rd) begin
        pend_cyc.push_back(cyc + LAT);
        pend_addr.push_back(m_iss);
        m_iss++;
      end
      if (exp_wr) begin
        void'(pend_cyc.pop_front());
        void'(pend_addr.pop_front());
        m_wr++;
        if (m_wr == N) begin m_act = 0; m_donecyc = 1; end
      end
    end
    cyc++;
  end

  // ---------------- order/latency checks for the combinational-multiplier build ----------------
  int cyc1 = 0;
  int d1_rd_next = 0, d1_wr_next = 0, d1_done_cyc = -1, d1_start_cyc = -1;
  int d1_rdcyc [N];
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.start && d1_start_cyc < 0) d1_start_cyc = cyc1;
      if (bus1.rd_en) begin
        chk("d1_rd_addr", bus1.rd_addr, d1_rd_next);
        d1_rdcyc[bus1.rd_addr] = cyc1;
        d1_rd_next++;
      end
      if (bus1.wr_en) begin
        chk("d1_wr_addr", bus1.wr_addr, d1_wr_next);
        chk("d1_wr_latency", cyc1 - d1_rdcyc[bus1.wr_addr], 1);
        chk("d1_wr_data", bus1.wr_data, gold(int'(bus1.wr_addr)));
        d1_wr_next++;
      end
      if (bus1.done) d1_done_cyc = cyc1;
    end
    cyc1++;
  end

  // ---------------- stimulus ----------------
  task automatic load_rand();
    for (int j = 0; j < N; j++) begin
      f0[j] = 16'($urandom_range(0, Q-1)); f1[j] = 16'($urandom_range(0, Q-1));
      g0[j] = 16'($urandom_range(0, Q-1)); g1[j] = 16'($urandom_range(0, Q-1));
      zt[j] = 16'($urandom_range(0, Q-1));
    end
  endtask

  function automatic bit stall_pat(input int k);
    return (k >= 10 && k <= 19) || (k >= 138 && k <= 140) || (k >= 143 && k <= 145);
  endfunction

  // mode 0: no stall, 1: fixed stall pattern, 2: start held through run, 3: random stall
  task automatic run0(input int mode, input bit with_dut1);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.stall = 1'b0;
    if (with_dut1) bus1.start = 1'b1;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(posedge clk); #1;
      bus0.start = (mode == 2) && (k <= 132);
      bus1.start = 1'b0;
      case (mode)
        1:       bus0.stall = stall_pat(k);
        3:       bus0.stall = 1'($urandom_range(0, 1));
        default: bus0.stall = 1'b0;
      endcase
      @(negedge clk);
      if (bus0.done) seen = 1;
    end
    chk("done_within_budget", seen, 1);
    @(posedge clk); #1;
    bus0.start = 1'b0; bus0.stall = 1'b0;
  endtask

  initial begin
    int d;
    bus0.start = 0; bus0.stall = 0; bus1.start = 0; bus1.stall = 0;
    load_rand();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // abort mid-run after 40 issues, then a clean run
    bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_write_count", obs_wr_cnt, 37);
    run0(0, 0);
    chk("after_abort_done_offset", obs_done_cyc - start_cyc, 132);
    chk("after_abort_write_count", obs_wr_cnt, 128);

    // all-ones operands, zetas = 0..127, both builds together
    for (int j = 0; j < N; j++) begin
      f0[j] = 16'd1; f1[j] = 16'd1; g0[j] = 16'd1; g1[j] = 16'd1; zt[j] = 16'(j);
    end
    run0(0, 1);
    chk("ones_done_offset", obs_done_cyc - start_cyc, 132);
    chk("ones_first_read_offset", obs_rd0_cyc - start_cyc, 1);
    chk("ones_first_write_offset", obs_wr0_cyc - start_cyc, 4);
    chk("ones_h0", h0[0], 32'h0002_0001);
    chk("ones_h127", h0[127], 32'h0002_0080);
    chk("lat0_done_offset", d1_done_cyc - d1_start_cyc, 130);
    chk("lat0_write_count", d1_wr_next, 128);

    // fixed stall window plus stall at the last issue and during drain
    load_rand();
    run0(1, 0);
    chk("stall_done_offset", obs_done_cyc - start_cyc, 145);
    chk("stall_write_count", obs_wr_cnt, 128);

    // start held high through the run and in the done cycle
    load_rand();
    d = obs_done_cnt;
    run0(2, 0);
    chk("held_start_done_offset", obs_done_cyc - start_cyc, 132);
    repeat (15) @(posedge clk);
    #1;
    chk("held_start_single_run", obs_done_cnt - d, 1);
    chk("held_start_idle_after", bus0.busy, 0);

    // random stall runs
    for (int r = 0; r < 20; r++) begin
      load_rand();
      run0(3, 0);
      chk("rand_write_count", obs_wr_cnt, 128);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
